// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: hold/flush arbitration, multi-cycle execute and flush window.
// Stall and done are combinational from state and requests; flush_o is registered.
module pipe_ctrl #(
  parameter int CNT_W        = 6,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_lu_req,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_len,
  input  logic             mem_wait,
  input  logic             flush_req,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             ex_mc_done_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_HOLD = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       fcnt, fcnt_nxt;
  logic             flush_nxt;
  logic [5:0]       stall;
  logic             done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      cnt     <= '0;
      fcnt    <= 2'd0;
      flush_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      fcnt    <= fcnt_nxt;
      flush_o <= flush_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fcnt_nxt  = fcnt;
    flush_nxt = flush_o;
    stall     = 6'b000000;
    done      = 1'b0;
    if (flush_req) begin
      // Aborts any multi-cycle op in flight; a flush during FLUSH restarts the window.
      state_nxt = FLUSH;
      fcnt_nxt  = FLUSH_LOAD;
      flush_nxt = 1'b1;
      cnt_nxt   = '0;
    end else if (state == FLUSH) begin
      fcnt_nxt = fcnt - 2'd1;
      if (fcnt == 2'd1) begin
        flush_nxt = 1'b0;
        state_nxt = RUN;
      end
    end else if (mem_wait) begin
      stall = 6'b011111;
    end else if (state == EX_HOLD) begin
      if (cnt > ONE) begin
        stall   = 6'b001111;
        cnt_nxt = cnt - ONE;
      end else begin
        done      = 1'b1;
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end else begin
      // RUN (the unused encoding also falls back here).
      state_nxt = RUN;
      if (ex_mc_start && ex_mc_len >= TWO) begin
        stall     = 6'b001111;
        cnt_nxt   = ex_mc_len - ONE;
        state_nxt = EX_HOLD;
      end else if (id_lu_req) begin
        stall = 6'b000111;
      end
    end
  end

  assign stall_o      = rst ? stall : 6'b000000;
  assign ex_mc_done_o = rst & done;
  assign busy_o       = rst & (state != RUN);
  assign state_o      = rst ? state : 2'd0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed literal checks plus randomized traffic vs a behavioural model.
module tb_pipe_ctrl;
  localparam int CNT_W = 6;
  localparam int FC    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             id_lu_req = 1'b0;
  logic             ex_mc_start = 1'b0;
  logic [CNT_W-1:0] ex_mc_len = '0;
  logic             mem_wait = 1'b0;
  logic             flush_req = 1'b0;
  logic [5:0]       stall_o;
  logic             flush_o;
  logic             ex_mc_done_o;
  logic             busy_o;
  logic [1:0]       state_o;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .id_lu_req(id_lu_req), .ex_mc_start(ex_mc_start),
    .ex_mc_len(ex_mc_len), .mem_wait(mem_wait), .flush_req(flush_req),
    .stall_o(stall_o), .flush_o(flush_o), .ex_mc_done_o(ex_mc_done_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: an op of length L costs L-1 stall cycles then one done cycle;
  // mem_wait simply pauses the countdown; flush owns the next FC cycles.
  bit m_holding   = 0;
  int m_stalls    = 0;  // hold-stall cycles still owed before the done cycle
  int m_flush     = 0;  // flush cycles still to be shown

  always @(negedge clk) begin
    logic [5:0] e_stall;
    logic       e_done, e_flush, e_busy;
    logic [1:0] e_state;
    e_stall = 6'b0;
    e_done  = 1'b0;
    if (!rst) begin
      m_holding = 0;
      m_stalls  = 0;
      m_flush   = 0;
      e_flush = 1'b0; e_busy = 1'b0; e_state = 2'd0;
    end else begin
      e_flush = (m_flush > 0);
      e_busy  = (m_flush > 0) || m_holding;
      e_state = (m_flush > 0) ? 2'd2 : (m_holding ? 2'd1 : 2'd0);
      if (flush_req || m_flush > 0) e_stall = 6'b0;
      else if (mem_wait) e_stall = 6'b011111;
      else if (m_holding) begin
        if (m_stalls > 0) e_stall = 6'b001111;
        else e_done = 1'b1;
      end else if (ex_mc_start && ex_mc_len >= 2) e_stall = 6'b001111;
      else if (id_lu_req) e_stall = 6'b000111;
    end
    chk("stall", {2'b0, stall_o}, {2'b0, e_stall});
    chk("done",  {7'b0, ex_mc_done_o}, {7'b0, e_done});
    chk("flush", {7'b0, flush_o}, {7'b0, e_flush});
    chk("busy",  {7'b0, busy_o}, {7'b0, e_busy});
    chk("state", {6'b0, state_o}, {6'b0, e_state});
    if (rst) begin
      if (flush_req) begin
        m_flush   = FC;
        m_holding = 0;
        m_stalls  = 0;
      end else if (m_flush > 0) m_flush--;
      else if (mem_wait) begin
      end else if (m_holding) begin
        if (m_stalls > 0) m_stalls--;
        else m_holding = 0;
      end else if (ex_mc_start && ex_mc_len >= 2) begin
        m_holding = 1;
        m_stalls  = int'(ex_mc_len) - 2;
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, then settle before literal checks.
  task automatic step(input logic r, input logic lu, input logic st, input int len,
                      input logic mw, input logic fr);
    @(posedge clk);
    #1;
    rst = r; id_lu_req = lu; ex_mc_start = st; ex_mc_len = CNT_W'(len);
    mem_wait = mw; flush_req = fr;
    #2;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with every request high.
    step(0, 1, 1, 5, 1, 1);
    chk("rst_stall", {2'b0, stall_o}, 8'h00);
    chk("rst_flush", {7'b0, flush_o}, 8'h00);
    chk("rst_state", {6'b0, state_o}, 8'h00);
    step(0, 1, 1, 5, 1, 1);
    chk("rst_done", {7'b0, ex_mc_done_o}, 8'h00);
    chk("rst_busy", {7'b0, busy_o}, 8'h00);
    idle();
    chk("rel_state", {6'b0, state_o}, 8'h00);

    // len = 5: four stall cycles then done.
    step(1, 0, 1, 5, 0, 0);
    chk("mc5_c1", {2'b0, stall_o}, 8'h0f);
    idle(); idle(); idle();
    chk("mc5_c4", {2'b0, stall_o}, 8'h0f);
    chk("mc5_st", {6'b0, state_o}, 8'h01);
    idle();
    chk("mc5_done", {7'b0, ex_mc_done_o}, 8'h01);
    chk("mc5_c5stall", {2'b0, stall_o}, 8'h00);
    idle();
    chk("mc5_run", {6'b0, state_o}, 8'h00);

    // len = 4 with two mem_wait cycles: done in cycle 6.
    step(1, 0, 1, 4, 0, 0);
    idle();
    step(1, 0, 0, 0, 1, 0);
    chk("mw_stall", {2'b0, stall_o}, 8'h1f);
    step(1, 0, 0, 0, 1, 0);
    idle();
    chk("mw_c5", {2'b0, stall_o}, 8'h0f);
    idle();
    chk("mw_done", {7'b0, ex_mc_done_o}, 8'h01);

    // Flush in the second EX_HOLD cycle aborts the op.
    step(1, 0, 1, 5, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 1);
    chk("fl_stall", {2'b0, stall_o}, 8'h00);
    idle();
    chk("fl_c1", {7'b0, flush_o}, 8'h01);
    chk("fl_state", {6'b0, state_o}, 8'h02);
    idle();
    chk("fl_c2", {7'b0, flush_o}, 8'h01);
    idle();
    chk("fl_end", {7'b0, flush_o}, 8'h00);
    chk("fl_run", {6'b0, state_o}, 8'h00);
    chk("fl_nodone", {7'b0, ex_mc_done_o}, 8'h00);

    // Load-use together with a len=3 op: hold wins, load-use seen after return to RUN.
    step(1, 1, 1, 3, 0, 0);
    chk("lu_c1", {2'b0, stall_o}, 8'h0f);
    step(1, 1, 0, 0, 0, 0);
    chk("lu_c2", {2'b0, stall_o}, 8'h0f);
    step(1, 1, 0, 0, 0, 0);
    chk("lu_done", {7'b0, ex_mc_done_o}, 8'h01);
    step(1, 1, 0, 0, 0, 0);
    chk("lu_run", {2'b0, stall_o}, 8'h07);

    // Degenerate lengths.
    step(1, 0, 1, 0, 0, 0);
    chk("len0", {2'b0, stall_o}, 8'h00);
    step(1, 0, 1, 1, 0, 0);
    chk("len1", {2'b0, stall_o}, 8'h00);
    idle();
    chk("len1_st", {6'b0, state_o}, 8'h00);

    // Reset during EX_HOLD, then a fresh short op works from a clean counter.
    step(1, 0, 1, 10, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0);
    chk("ra_stall", {2'b0, stall_o}, 8'h00);
    chk("ra_state", {6'b0, state_o}, 8'h00);
    idle();
    chk("ra_nodone", {7'b0, ex_mc_done_o}, 8'h00);
    step(1, 0, 1, 2, 0, 0);
    idle();
    chk("ra_len2", {7'b0, ex_mc_done_o}, 8'h01);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      int len;
      len = ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, 9));
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           len,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 29) == 0));
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It collects hold requests from decode (load-use), execute (multi-cycle ALU operations) and memory (wait states), plus flush requests from exception logic. It produces the per-stage stall vector and the flush strobe consumed by the pc, if/id, id/ex, ex/mem and mem/wb pipeline registers. The multi-cycle execute sequencing and the flush window are owned here as a small state machine with a cycle counter.

## Interface
- CNT_W, 6: width of multi-cycle length and internal counter.
- FLUSH_CYCLES, 1: number of cycles flush_o stays high after a flush request; legal range 1..3.

- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_lu_req  in  1  decode needs the result of a load currently in execute; one bubble required.
- ex_mc_start  in  1  execute begins a multi-cycle op this cycle; sampled only in RUN.
- ex_mc_len  in  CNT_W  total execute occupancy in cycles, valid with ex_mc_start.
- mem_wait  in  1  memory stage not ready; hold everything up to and including mem.
- flush_req  in  1  single-cycle flush request from exception logic.
- stall_o  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold register.
- flush_o  out  1  clear all pipeline registers to NOP.
- ex_mc_done_o  out  1  final cycle of a multi-cycle op; execute result valid.
- busy_o  out  1  state != RUN.
- state_o  out  2  RUN=0, EX_HOLD=1, FLUSH=2; 3 unused.

## Operation
- State register, CNT_W counter cnt, flush counter fcnt (2 bits); all cleared asynchronously when rst low: state RUN, cnt 0, fcnt 0, flush_o 0.
- stall_o, ex_mc_done_o combinational from state, cnt and inputs; flush_o registered.
- While rst low, stall_o = 0, ex_mc_done_o = 0, busy_o = 0, state_o = 0.
- Priority every cycle: flush_req > mem_wait > multi-cycle hold > id_lu_req.
- flush_req (any state): stall_o = 0 that cycle; next state FLUSH, fcnt <= FLUSH_CYCLES, flush_o <= 1, cnt <= 0. An in-flight multi-cycle op is aborted with no ex_mc_done_o.
- FLUSH: flush_o high; stall_o = 0; all other requests ignored; fcnt decrements each cycle; when fcnt == 1, flush_o <= 0 and state <= RUN. A new flush_req in FLUSH reloads fcnt.
- mem_wait (not FLUSH, no flush_req): stall_o = 6'b011111. The cnt decrement is frozen. ex_mc_start in RUN is not accepted that cycle; execute re-presents it.
- RUN, ex_mc_start, ex_mc_len >= 2: stall_o = 6'b001111; cnt <= ex_mc_len - 1; state <= EX_HOLD.
- ex_mc_len of 0 or 1 is a single-cycle op: no stall, no state change, ex_mc_done_o = 0.
- EX_HOLD, cnt > 1: stall_o = 6'b001111; cnt <= cnt - 1.
- EX_HOLD, cnt == 1: stall_o = 0, ex_mc_done_o = 1; state <= RUN, cnt <= 0.
- id_lu_req and ex_mc_start are ignored in EX_HOLD.
- RUN, id_lu_req only: stall_o = 6'b000111 for that cycle (id/ex receives a bubble); no state change. Decode deasserts the request once the load advances.
- ex_mc_start and id_lu_req together in RUN: multi-cycle hold wins. Load-use is re-evaluated after return to RUN.
- Reset asserted mid-operation aborts everything immediately, with no done or flush pulse.

## Timing
- Multi-cycle op of length L >= 2: stall_o[3:0] high for exactly L-1 cycles starting at the ex_mc_start cycle. ex_mc_done_o is high in cycle L, and stall_o = 0 in the same cycle.
- Each mem_wait cycle during EX_HOLD extends the hold by one cycle.
- Flush: flush_o rises the cycle after flush_req and stays high for FLUSH_CYCLES cycles. busy_o is high for the same cycles.
- Load-use costs exactly one stall cycle per asserted cycle; zero-latency combinational response.
- Maximum L = 2^CNT_W - 1; no wrap, since cnt never loads 0 from the EX_HOLD path.

## Test plan
- Reset: hold rst low with all requests high -> stall_o = 0, flush_o = 0, state_o = 0. Release rst -> RUN.
- Multi-cycle: ex_mc_start with len = 5 -> stall_o = 6'b001111 for 4 cycles, then ex_mc_done_o = 1 with stall_o = 0 for 1 cycle, then state_o = 0.
- mem_wait inside hold: len = 4 with mem_wait high for 2 cycles during EX_HOLD -> stall_o = 6'b011111 during the wait; done arrives 2 cycles later than without wait (cycle 6).
- Flush abort: flush_req in the second EX_HOLD cycle -> stall_o = 0 that cycle. With FLUSH_CYCLES = 2, flush_o is high for 2 cycles, ex_mc_done_o never pulses, and state returns to RUN.
- Load-use vs multi-cycle: id_lu_req with ex_mc_start (len = 3) in the same cycle -> 6'b001111 for 2 cycles. A persisting id_lu_req then yields 6'b000111 in RUN.
- Degenerate lengths and reset abort: len = 0 and len = 1 -> no stall, no done. Asserting rst during EX_HOLD -> outputs zero immediately, cnt = 0.
